// File: rtl/axis_pixel_transmitter.sv
// Pixel stream to AXI4-Stream master with tuser/tlast framing and FIFO.
// Optional macro AXIS_TX_FRAME_CNT_EN adds o_frame_count.
module axis_pixel_transmitter #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 10,
  parameter int IMAGE_HEIGHT = 10,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic                  i_start_of_frame,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
`ifdef AXIS_TX_FRAME_CNT_EN
  output logic [15:0]           o_frame_count,
`endif
  output logic                  o_overflow,
  output logic                  o_frame_error,
  output logic                  o_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT + 1);
`ifdef AXIS_TX_FRAME_CNT_EN
  localparam int EW = DATA_WIDTH + 3;
`else
  localparam int EW = DATA_WIDTH + 2;
`endif

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          wr_en;
  logic          wr_tlast;
  logic          wr_fend;
  logic [EW-1:0] wr_entry;
  logic          pop;
  logic          push;
  logic          full;
  logic [AW:0]   cnt_after;
  logic [AW-1:0] rd_nxt;
  logic [EW-1:0] head_n;
  logic          tvalid_n;
`ifdef AXIS_TX_FRAME_CNT_EN
  logic          fend_q;
`endif

  // Decode the entry the incoming pixel would produce.
  always_comb begin
    wr_en    = i_data_valid & (i_start_of_frame | (state == ACTIVE));
    wr_tlast = ~i_start_of_frame & (col == CW'(IMAGE_WIDTH - 1));
    wr_fend  = wr_tlast & (row == RW'(IMAGE_HEIGHT - 1));
`ifdef AXIS_TX_FRAME_CNT_EN
    wr_entry = {i_start_of_frame, wr_tlast, wr_fend, i_data};
`else
    wr_entry = {i_start_of_frame, wr_tlast, i_data};
`endif
  end

  assign pop       = m_axis_tvalid & m_axis_tready;
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign push      = wr_en & (~full | pop);
  assign cnt_after = count - (AW+1)'(pop);
  assign rd_nxt    = rd_ptr + AW'(pop);

  // Next head of queue: oldest surviving entry, else the bypassed write.
  always_comb begin
    head_n   = mem[rd_nxt];
    tvalid_n = 1'b1;
    if (cnt_after == '0) begin
      head_n   = wr_entry;
      tvalid_n = push;
    end
  end

  // Write-side framing FSM and early-SOF detection.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= WAIT_SOF;
      col           <= '0;
      row           <= '0;
      o_frame_error <= 1'b0;
    end else begin
      o_frame_error <= 1'b0;
      if (i_data_valid) begin
        if (i_start_of_frame) begin
          o_frame_error <= (state == ACTIVE);
          state         <= ACTIVE;
          col           <= CW'(1);
          row           <= '0;
        end else if (state == ACTIVE) begin
          if (col == CW'(IMAGE_WIDTH - 1)) begin
            col <= '0;
            if (row == RW'(IMAGE_HEIGHT - 1)) begin
              row   <= '0;
              state <= WAIT_SOF;
            end else begin
              row <= row + RW'(1);
            end
          end else begin
            col <= col + CW'(1);
          end
        end
      end
    end
  end

  // Storage array; contents need no reset since count gates them.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // Pointers, occupancy, registered output stage and status flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      o_overflow    <= 1'b0;
`ifdef AXIS_TX_FRAME_CNT_EN
      fend_q        <= 1'b0;
      o_frame_count <= '0;
`endif
    end else begin
      wr_ptr        <= wr_ptr + AW'(push);
      rd_ptr        <= rd_nxt;
      count         <= cnt_after + (AW+1)'(push);
      m_axis_tvalid <= tvalid_n;
      if (tvalid_n) begin
        m_axis_tdata <= head_n[DATA_WIDTH-1:0];
        m_axis_tuser <= head_n[EW-1];
        m_axis_tlast <= head_n[EW-2];
`ifdef AXIS_TX_FRAME_CNT_EN
        fend_q       <= head_n[DATA_WIDTH];
`endif
      end
      if (wr_en & ~push) o_overflow <= 1'b1;
`ifdef AXIS_TX_FRAME_CNT_EN
      if (pop & m_axis_tlast & fend_q)
        o_frame_count <= o_frame_count + 16'd1;
`endif
    end
  end

  assign o_busy = (state == ACTIVE) | (count != '0) | m_axis_tvalid;

endmodule
